// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter: FSM encoding and default sizes.
package mem_arb_pkg;

   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int NUM_REQ_DEF    = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side bus of the memory arbiter: flattened per-requester request lanes plus grant/response.
interface mem_arb_if
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]            lock;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]         rdata;

   modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: first requester after the last winner, wrapping at NUM_REQ-1.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic               valid_o,
   output logic [NUM_REQ-1:0] win_oh_o,
   output logic [IDX_W-1:0]   win_idx_o
);

   always_comb begin
      valid_o   = 1'b0;
      win_oh_o  = '0;
      win_idx_o = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int c;
         c = (int'(last_i) + k) % NUM_REQ;
         if (!valid_o && req_i[c]) begin
            valid_o     = 1'b1;
            win_oh_o[c] = 1'b1;
            win_idx_o   = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to let a locked winner chain accesses without re-arbitrating.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for requests; arbitrates and latches the winner
// ST_ISSUE | gnt pulse, RAM load/oe driven from latched access
// ST_RESP  | read data returned with rvalid
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_REQ    = NUM_REQ_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_arb_if.slave              bus,
   output logic                  mem_load,
   output logic                  mem_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   localparam int IDX_W = idx_width(NUM_REQ);

   logic [1:0]            state_q,   state_d;
   logic [NUM_REQ-1:0]    win_oh_q,  win_oh_d;
   logic [IDX_W-1:0]      win_idx_q, win_idx_d;
   logic                  we_q,      we_d;
   logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;

   logic                  pick_valid;
   logic [NUM_REQ-1:0]    pick_oh;
   logic [IDX_W-1:0]      pick_idx;
   logic                  hold;
   logic                  take;
   logic [NUM_REQ-1:0]    sel_oh;
   logic [IDX_W-1:0]      sel_idx;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i     (bus.req),
      .last_i    (win_idx_q),
      .valid_o   (pick_valid),
      .win_oh_o  (pick_oh),
      .win_idx_o (pick_idx)
   );

`ifdef MEM_ARB_LOCK_EN
   assign hold = bus.lock[win_idx_q] & bus.req[win_idx_q];
`else
   logic unused_lock;
   assign unused_lock = ^bus.lock;
   assign hold        = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      win_oh_d  = win_oh_q;
      win_idx_d = win_idx_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      take      = 1'b0;
      sel_oh    = pick_oh;
      sel_idx   = pick_idx;
      case (state_q)
         ST_IDLE:  take    = pick_valid;
         ST_ISSUE: state_d = we_q ? ST_IDLE : ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Locked winner in its last cycle re-issues straight away with its fresh inputs.
      if (hold && (((state_q == ST_ISSUE) && we_q) || (state_q == ST_RESP))) begin
         take    = 1'b1;
         sel_oh  = win_oh_q;
         sel_idx = win_idx_q;
      end
      if (take) begin
         state_d   = ST_ISSUE;
         win_oh_d  = sel_oh;
         win_idx_d = sel_idx;
         we_d      = bus.we[sel_idx];
         addr_d    = bus.addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
         wdata_d   = bus.wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         win_oh_q  <= '0;
         win_idx_q <= IDX_W'(NUM_REQ - 1);
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         win_oh_q  <= win_oh_d;
         win_idx_q <= win_idx_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus.gnt     = (state_q == ST_ISSUE) ? win_oh_q : '0;
   assign bus.rvalid  = (state_q == ST_RESP)  ? win_oh_q : '0;
   assign bus.rdata   = (state_q == ST_RESP)  ? mem_data_out : '0;
   assign mem_load    = (state_q == ST_ISSUE) &  we_q;
   assign mem_oe      = (state_q == ST_ISSUE) & ~we_q;
   assign mem_addr    = addr_q;
   assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: transaction-level schedule model plus directed and random traffic.
module tb_mem_arb;
   import mem_arb_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int NR = 3;

`ifdef MEM_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   logic          mem_load, mem_oe;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in, mem_data_out;

   mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .mem_load     (mem_load),
      .mem_oe       (mem_oe),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // RAM port with registered read data (driven as 0 when not enabled)
   logic [DW-1:0] ram [2**AW];
   always @(posedge clk) begin
      if (mem_load) ram[mem_addr] <= mem_data_in;
      mem_data_out <= mem_oe ? ram[mem_addr] : '0;
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          lock;
   } op_t;

   typedef struct packed {
      logic [NR-1:0] gnt;
      logic [NR-1:0] rvalid;
      logic          load;
      logic          oe;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct {
      int            c;
      logic [NR-1:0] g;
      logic          ld;
      logic          oe;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } glog_t;

   typedef struct {
      int            c;
      logic [NR-1:0] v;
      logic [DW-1:0] d;
   } rlog_t;

   op_t   opq [NR][$];
   exp_t  ex [int];
   glog_t glog [$];
   rlog_t rlog [$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit busy     = 1'b0;
   int final_c  = 0;
   int last     = NR - 1;
   logic [DW-1:0] mmem [2**AW];

   // ---------------- reference model: schedule of expected outputs per cycle ----------------
   function automatic void issue(input int w, input int n);
      exp_t e;
      exp_t r;
      e = '0;
      r = '0;
      busy   = 1'b1;
      last   = w;
      e.gnt  = NR'(1 << w);
      e.addr = bus.addr[w*AW +: AW];
      e.din  = bus.wdata[w*DW +: DW];
      if (bus.we[w]) begin
         e.load        = 1'b1;
         mmem[e.addr]  = e.din;
         final_c       = n;
      end else begin
         e.oe     = 1'b1;
         r.rvalid = NR'(1 << w);
         r.rdata  = mmem[e.addr];
         ex[n+1]  = r;
         final_c  = n + 1;
      end
      ex[n] = e;
   endfunction

   always @(posedge clk) begin : model_blk
      int n;
      n = cyc + 1;
      if (rst) begin
         busy = 1'b0;
         last = NR - 1;
         ex.delete();
      end else if (busy) begin
         if (n - 1 == final_c) begin
            busy = 1'b0;
            if (LOCK_EN && bus.lock[last] && bus.req[last]) issue(last, n);
         end
      end else if (|bus.req) begin
         for (int k = 1; k <= NR; k++) begin
            int c;
            c = (last + k) % NR;
            if (!busy && bus.req[c]) issue(c, n);
         end
      end
      cyc = n;
   end

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   task automatic compare();
      exp_t e;
      e = ex.exists(cyc) ? ex[cyc] : '0;
      check("gnt",      bus.gnt,    e.gnt);
      check("rvalid",   bus.rvalid, e.rvalid);
      check("rdata",    bus.rdata,  e.rdata);
      check("mem_load", mem_load,   e.load);
      check("mem_oe",   mem_oe,     e.oe);
      if (e.load || e.oe) begin
         check("mem_addr",    mem_addr,    e.addr);
         check("mem_data_in", mem_data_in, e.din);
      end
      if (|bus.gnt)    glog.push_back('{cyc, bus.gnt, mem_load, mem_oe, mem_addr, mem_data_in});
      if (|bus.rvalid) rlog.push_back('{cyc, bus.rvalid, bus.rdata});
   endtask

   // ---------------- requesters ----------------
   task automatic present();
      for (int i = 0; i < NR; i++) begin
         if (opq[i].size() > 0) begin
            bus.req[i]             = 1'b1;
            bus.we[i]              = opq[i][0].we;
            bus.addr[i*AW +: AW]   = opq[i][0].addr;
            bus.wdata[i*DW +: DW]  = opq[i][0].wdata;
            bus.lock[i]            = opq[i][0].lock;
         end else begin
            bus.req[i]             = 1'b0;
            bus.lock[i]            = 1'b0;
            bus.we[i]              = 1'($urandom);
            bus.addr[i*AW +: AW]   = AW'($urandom);
            bus.wdata[i*DW +: DW]  = DW'($urandom);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      for (int i = 0; i < NR; i++)
         if (bus.gnt[i] && opq[i].size() > 0) void'(opq[i].pop_front());
      present();
   endtask

   task automatic push(input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic l);
      op_t o;
      o.we = w; o.addr = a; o.wdata = d; o.lock = l;
      opq[i].push_back(o);
   endtask

   function automatic bit all_idle();
      bit r;
      r = !busy;
      for (int i = 0; i < NR; i++) if (opq[i].size() > 0) r = 1'b0;
      return r;
   endfunction

   task automatic wait_idle(input string nm);
      int b;
      b = 0;
      while (!all_idle() && b < 400) begin
         step();
         b++;
      end
      if (!all_idle()) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout cyc=%0d actual=busy required=idle", nm, cyc);
      end
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk_g(input string nm, input int k, input int c_req, input int idx_req);
      check({nm, "_present"}, 64'(glog.size() > k), 64'd1);
      if (glog.size() > k) begin
         check({nm, "_cyc"}, 64'(glog[k].c), 64'(c_req));
         check({nm, "_idx"}, 64'(glog[k].g), 64'(1 << idx_req));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   initial begin
      int s;
      for (int i = 0; i < 2**AW; i++) begin
         ram[i]  = '0;
         mmem[i] = '0;
      end
      rst        = 1'b1;
      bus.req    = '0;
      bus.we     = '0;
      bus.addr   = '0;
      bus.wdata  = '0;
      bus.lock   = '0;

      do_reset();
      check("rst_gnt",    bus.gnt,     '0);
      check("rst_rvalid", bus.rvalid,  '0);
      check("rst_rdata",  bus.rdata,   '0);
      check("rst_load",   mem_load,    '0);
      check("rst_oe",     mem_oe,      '0);
      check("rst_addr",   mem_addr,    '0);
      check("rst_din",    mem_data_in, '0);

      // write from requester 0
      glog.delete(); rlog.delete();
      push(0, 1'b1, 4'd3, 8'hA5, 1'b0);
      present();
      s = cyc;
      wait_idle("t1");
      chk_g("t1", 0, s + 1, 0);
      if (glog.size() > 0) begin
         check("t1_load", glog[0].ld, 1'b1);
         check("t1_addr", glog[0].a, 4'd3);
         check("t1_din",  glog[0].d, 8'hA5);
      end

      // read back from requester 1
      glog.delete(); rlog.delete();
      push(1, 1'b0, 4'd3, 8'h00, 1'b0);
      present();
      s = cyc;
      wait_idle("t2");
      chk_g("t2", 0, s + 1, 1);
      if (glog.size() > 0) check("t2_oe", glog[0].oe, 1'b1);
      check("t2_rv_present", 64'(rlog.size()), 64'd1);
      if (rlog.size() > 0) begin
         check("t2_rv_cyc", 64'(rlog[0].c), 64'(s + 2));
         check("t2_rv_idx", rlog[0].v, 3'b010);
         check("t2_rdata",  rlog[0].d, 8'hA5);
      end

      // all three requesting reads: order 0,1,2,0, three cycles apart
      do_reset();
      glog.delete(); rlog.delete();
      for (int i = 0; i < NR; i++) begin
         push(i, 1'b0, AW'(i), 8'h00, 1'b0);
         push(i, 1'b0, AW'(i + 5), 8'h00, 1'b0);
      end
      present();
      s = cyc;
      wait_idle("t3");
      chk_g("t3g0", 0, s + 1,  0);
      chk_g("t3g1", 1, s + 4,  1);
      chk_g("t3g2", 2, s + 7,  2);
      chk_g("t3g3", 3, s + 10, 0);

      // reset during read ISSUE
      glog.delete(); rlog.delete();
      push(0, 1'b0, 4'd3, 8'h00, 1'b0);
      present();
      step();
      check("t4_gnt", bus.gnt, 3'b001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t4_rvalid", bus.rvalid,  '0);
      check("t4_gnt0",   bus.gnt,     '0);
      check("t4_rdata",  bus.rdata,   '0);
      check("t4_load",   mem_load,    '0);
      check("t4_oe",     mem_oe,      '0);
      check("t4_addr",   mem_addr,    '0);
      check("t4_din",    mem_data_in, '0);
      repeat (3) step();
      check("t4_no_rv", 64'(rlog.size()), 64'd0);

      // locked burst of writes from requester 0 while requester 1 waits
      do_reset();
      glog.delete(); rlog.delete();
      for (int k = 0; k < 4; k++) push(0, 1'b1, AW'(k + 4), DW'(8'h10 + k), 1'b1);
      push(1, 1'b1, 4'd12, 8'hC0, 1'b0);
      push(1, 1'b1, 4'd13, 8'hC1, 1'b0);
      present();
      s = cyc;
      wait_idle("t5");
`ifdef MEM_ARB_LOCK_EN
      chk_g("t5g0", 0, s + 1, 0);
      chk_g("t5g1", 1, s + 2, 0);
      chk_g("t5g2", 2, s + 3, 0);
      chk_g("t5g3", 3, s + 4, 0);
      chk_g("t5g4", 4, s + 6, 1);
`else
      chk_g("t5g0", 0, s + 1, 0);
      chk_g("t5g1", 1, s + 3, 1);
      chk_g("t5g2", 2, s + 5, 0);
      chk_g("t5g3", 3, s + 7, 1);
`endif

      // random traffic with occasional reset
      do_reset();
      for (int t = 0; t < 700; t++) begin
         if ($urandom_range(2) == 0) begin
            int i;
            i = int'($urandom_range(NR - 1));
            if (opq[i].size() < 3)
               push(i, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));
            present();
         end
         rst = ($urandom_range(199) == 0);
         step();
      end
      rst = 1'b0;
      wait_idle("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
